// File: rtl/reset_sequencer.sv
// Merges board, HPS and software reset sources into one held reset,
// then releases staged domain resets in index order with a sticky cause log.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int SYNC_DEPTH  = 2,
  parameter int HOLD_CYCLES = 100,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  src_reset_n_in,
  input  logic                  h2f_reset_in,
  input  logic                  sw_reset_req,
  input  logic                  rst_cause_clr,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  seq_done,
  output logic [3:0]            rst_cause
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
    CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST =
    CNT_WIDTH'(STAGE_GAP - 1);
  localparam logic [NUM_STAGES-1:0] FIRST =
    NUM_STAGES'(1);

  logic [SYNC_DEPTH-1:0] r_src_sync;
  logic [SYNC_DEPTH-1:0] r_h2f_sync;
  logic [SYNC_DEPTH-1:0] r_prime;
  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [NUM_STAGES-1:0] r_stage;
  logic                  r_done;
  logic [3:0]            r_cause;

  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [NUM_STAGES-1:0] w_stage_nxt;
  logic                  w_done_nxt;
  logic [3:0]            w_cause_nxt;
  logic                  w_src_act;
  logic                  w_h2f_act;
  logic                  w_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src_sync <= '0;
      r_h2f_sync <= '1;
      r_prime    <= '0;
    end else begin
      r_src_sync <= {r_src_sync[SYNC_DEPTH-2:0], src_reset_n_in};
      r_h2f_sync <= {r_h2f_sync[SYNC_DEPTH-2:0], h2f_reset_in};
      r_prime    <= {r_prime[SYNC_DEPTH-2:0], 1'b1};
    end
  end

  assign w_src_act = ~r_src_sync[SYNC_DEPTH-1];
  assign w_h2f_act = r_h2f_sync[SYNC_DEPTH-1];
  assign w_req     = w_src_act | w_h2f_act | sw_reset_req;

  // Flush values after reset are not real source activity
  assign w_cause_nxt =
    (rst_cause_clr ? 4'b0000 : r_cause) |
    {sw_reset_req,
     w_h2f_act & r_prime[SYNC_DEPTH-1],
     w_src_act & r_prime[SYNC_DEPTH-1],
     1'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_stage <= '0;
      r_done  <= 1'b0;
      r_cause <= 4'b0001;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
      r_done  <= w_done_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_done_nxt  = r_done;
    unique case (r_state)
      S_HOLD: begin
        w_stage_nxt = '0;
        w_done_nxt  = 1'b0;
        if (w_req) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_stage_nxt = FIRST;
          if (NUM_STAGES == 1) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        if (w_req) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
          w_done_nxt  = 1'b0;
        end else if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_stage_nxt = (r_stage << 1) | FIRST;
          if (w_stage_nxt[NUM_STAGES-1]) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (w_req) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
          w_done_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = '0;
        w_stage_nxt = '0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  assign stage_reset_n = r_stage;
  assign seq_done      = r_done;
  assign rst_cause     = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected values are queued as
// stimulus is applied and popped when the DUT response is sampled.
module tb_reset_sequencer;

  localparam int NS   = 3;
  localparam int SD   = 2;
  localparam int HOLD = 100;
  localparam int GAP  = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          src_reset_n_in = 1'b1;
  logic          h2f_reset_in = 1'b0;
  logic          sw_reset_req = 1'b0;
  logic          rst_cause_clr = 1'b0;
  logic [NS-1:0] stage_reset_n;
  logic          seq_done;
  logic [3:0]    rst_cause;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];

  reset_sequencer #(
    .NUM_STAGES (NS),
    .SYNC_DEPTH (SD),
    .HOLD_CYCLES(HOLD),
    .STAGE_GAP  (GAP),
    .CNT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .src_reset_n_in(src_reset_n_in),
    .h2f_reset_in  (h2f_reset_in),
    .sw_reset_req  (sw_reset_req),
    .rst_cause_clr (rst_cause_clr),
    .stage_reset_n (stage_reset_n),
    .seq_done      (seq_done),
    .rst_cause     (rst_cause)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h",
               e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input int idx, input int budget,
                           output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!stage_reset_n[idx] && n < budget);
  endtask

  task automatic wait_low(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (stage_reset_n != '0 && n < budget);
  endtask

  initial begin
    int n;

    // Reset state
    #12;
    push("rst_stage", 0);
    check(32'(stage_reset_n));
    push("rst_done", 0);
    check(32'(seq_done));
    push("rst_cause", 4'b0001);
    check(32'(rst_cause));

    // 1: release with idle inputs; syncs flush before hold starts
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push("t1_stage0_edges", SD + HOLD);
    wait_rise(0, 400, n);
    check(32'(n));
    push("t1_stage0_only", 3'b001);
    check(32'(stage_reset_n));
    push("t1_stage1_gap", GAP);
    wait_rise(1, 100, n);
    check(32'(n));
    push("t1_done_before", 0);
    check(32'(seq_done));
    push("t1_stage2_gap", GAP);
    wait_rise(2, 100, n);
    check(32'(n));
    push("t1_done", 1);
    check(32'(seq_done));
    push("t1_cause", 4'b0001);
    check(32'(rst_cause));

    // 2: board reset low for 5 cycles while running
    src_reset_n_in = 1'b0;
    push("t2_assert_lat", SD + 1);
    wait_low(20, n);
    check(32'(n));
    push("t2_done_low", 0);
    check(32'(seq_done));
    tick();
    tick();
    src_reset_n_in = 1'b1;
    push("t2_stage0_edges", SD + HOLD);
    wait_rise(0, 400, n);
    check(32'(n));
    push("t2_cause", 4'b0011);
    check(32'(rst_cause));

    // 3: one-cycle h2f pulse during release
    h2f_reset_in = 1'b1;
    tick();
    h2f_reset_in = 1'b0;
    tick();
    tick();
    push("t3_stage_low", 3'b000);
    check(32'(stage_reset_n));
    push("t3_done_low", 0);
    check(32'(seq_done));
    push("t3_cause", 4'b0111);
    check(32'(rst_cause));
    push("t3_restart", HOLD);
    wait_rise(0, 400, n);
    check(32'(n));

    // 4: sw pulse enters hold, second pulse at count 50 restarts it
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    push("t4_sw_lat", 3'b000);
    check(32'(stage_reset_n));
    repeat (50) tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    push("t4_restart", HOLD + 1);
    wait_rise(0, 400, n);
    check(32'(n + 1));
    push("t4_cause", 4'b1111);
    check(32'(rst_cause));

    // 6: async reset in the middle of release
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    push("t6_stage", 3'b000);
    check(32'(stage_reset_n));
    push("t6_done", 0);
    check(32'(seq_done));
    push("t6_cause", 4'b0001);
    check(32'(rst_cause));

    // 5: clear and sw request in the same cycle
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) tick();
    push("t5_pre_cause", 4'b0001);
    check(32'(rst_cause));
    rst_cause_clr = 1'b1;
    sw_reset_req  = 1'b1;
    tick();
    rst_cause_clr = 1'b0;
    sw_reset_req  = 1'b0;
    push("t5_set_wins", 4'b1000);
    check(32'(rst_cause));
    rst_cause_clr = 1'b1;
    tick();
    rst_cause_clr = 1'b0;
    push("t5_clear", 4'b0000);
    check(32'(rst_cause));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
